// File: rtl/arb_pkg.sv
// arb_pkg: shared widths and FSM state encoding for the round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    typedef enum logic {ST_IDLE, ST_GRANT} state_t;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: request vector and grant outputs between requesters and arbiter.
interface rr_arbiter_8_if;
    import arb_pkg::*;
    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] gnt_idx;
    logic gnt_valid;
    logic timeout;
    modport master (output req, input gnt_idx, gnt_valid, timeout);
    modport slave (input req, output gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority first-set-bit search starting at ptr.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic any
);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
    end
    assign idx = ptr + off;
    assign any = |req;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with registered grant index.
// Optional forced-release hold limit compiled in with ARB_TIMEOUT_EN.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic clk,
    input logic rst,
    rr_arbiter_8_if.slave bus
);
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range");
    end
    state_t state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, gnt_idx, idx_n, pick_idx;
    logic pick_any, expire;
    rr_pick u_pick (.req(bus.req), .ptr(ptr), .idx(pick_idx), .any(pick_any));
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic timeout;
    // cnt equals the number of GRANT edges already survived, so expiry is one short of MAX_HOLD
    assign expire = cnt == 8'(MAX_HOLD - 1);
    always_ff @(posedge clk) begin
        cnt <= (rst || state == ST_IDLE) ? '0 : cnt + 8'd1;
        timeout <= !rst && state == ST_GRANT && bus.req[gnt_idx] && expire;
    end
    assign bus.timeout = timeout;
`else
    assign expire = 1'b0;
    assign bus.timeout = 1'b0;
`endif
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        idx_n = gnt_idx;
        if (state == ST_IDLE) begin
            state_n = pick_any ? ST_GRANT : ST_IDLE;
            idx_n = pick_any ? pick_idx : gnt_idx;
        end else if (!bus.req[gnt_idx] || expire) begin
            state_n = ST_IDLE;
            ptr_n = gnt_idx + IDX_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr <= '0;
            gnt_idx <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            gnt_idx <= idx_n;
        end
    end
    assign bus.gnt_idx = gnt_idx;
    assign bus.gnt_valid = state == ST_GRANT;
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that produces the registered 3-bit grant index driving the 3-to-8 decoder stage. The decoder's one-hot output becomes the per-requester grant strobe, qualified by `gnt_valid`. One request is granted at a time. The grant is held until the requester drops its request, or until an optional hold limit expires.

## Interface

Parameters:
- `MAX_HOLD`, default 16: maximum grant length in cycles when the timeout is compiled in; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 8: request vector; bit i high means requester i wants the resource.
- `gnt_idx` out 3: index of the current or last granted requester; feeds the decoder input.
- `gnt_valid` out 1: high while `gnt_idx` is an active grant.
- `timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation

- State machine has two states:
  - `IDLE`: no grant active.
  - `GRANT`: grant active.
- Internal 3-bit priority pointer `ptr` holds the index with highest priority.
- In `IDLE` with `req != 0`:
  - Select the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Register that index into `gnt_idx`.
  - Set `gnt_valid = 1` and enter `GRANT`.
- In `IDLE` with `req == 0`: no change.
- In `GRANT`, `req[gnt_idx]` is the only request bit examined; other bits are ignored.
  - While `req[gnt_idx]` is 1, stay in `GRANT`.
  - When `req[gnt_idx]` is 0, clear `gnt_valid`, set `ptr = gnt_idx + 1`, and enter `IDLE`.
- Pointer arithmetic is 3-bit with natural wrap (7 + 1 = 0).
- `gnt_idx` keeps its last value after release and is meaningful only when `gnt_valid` is 1.
- Reset values:
  - state = `IDLE`, `ptr = 0`, hold counter = 0.
  - `gnt_idx = 0`, `gnt_valid = 0`, `timeout = 0`.
- `rst` has priority over every other condition, including mid-grant; the cycle after `rst` is sampled high, all outputs are at reset values.

## Timing

- Grant latency: `req` is sampled at edge k while `IDLE` → `gnt_valid`/`gnt_idx` are valid after edge k (1 cycle).
- Release latency: `req[gnt_idx] = 0` is sampled at edge k → `gnt_valid` is low after edge k.
- Back-to-back grants: a minimum of one `IDLE` cycle (`gnt_valid` low) separates consecutive grants.
- Arbitration in `IDLE` uses only the `req` value present at that edge; nothing is queued.
- The new `ptr` takes effect for the arbitration immediately following the release.
- `timeout` is registered, high for exactly one cycle, and coincides with the first cycle in which `gnt_valid` is low.

## Configuration

- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter clears on grant and increments each `GRANT` cycle.
  - If `gnt_valid` has been high for `MAX_HOLD` cycles and `req[gnt_idx]` is still 1, the grant is revoked: `gnt_valid = 0`, `timeout = 1`, `ptr = gnt_idx + 1`, and the state returns to `IDLE`.
  - Counter width is 8 bits.
  - A voluntary release in the same cycle as expiry counts as normal: `timeout` stays 0.
- Undefined:
  - No counter is built and `MAX_HOLD` is unused.
  - `timeout` is tied to 0.
  - A grant lasts indefinitely while requested.

## Structure

- Shared package `arb_pkg` holds:
  - `N_REQ = 8`, `IDX_W = 3`.
  - The state encoding constants `ST_IDLE` / `ST_GRANT`.
- One combinational sub-module, `rr_pick`:
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Function: rotating-priority first-set-bit search.
- The top level holds the FSM, pointer, output registers, and the macro-guarded counter.

## Test plan

- Reset: `rst = 1` for 2 cycles with `req = 8'hFF` → `gnt_valid = 0`, `gnt_idx = 0`, `timeout = 0` throughout; first grant after release of `rst` is index 0.
- Single request:
  - `req = 8'b0010_0000` from reset → one cycle later `gnt_valid = 1`, `gnt_idx = 5`.
  - Then `req = 0` → next cycle `gnt_valid = 0`.
  - Following grant to `req = 8'hFF` is index 6.
- Wrap-around: with `ptr = 7` and `req = 8'b0000_0011` → grant 0; release bit 0 → one `IDLE` cycle, then grant 1.
- Fairness: `req = 8'hFF`, with each grantee dropping its bit 2 cycles after grant and reasserting one cycle later → grant sequence 0,1,2,…,7,0, with one gap cycle between grants.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD = 4`):
  - `req = 8'b0000_1000` held → `gnt_valid` high 4 cycles, then low with `timeout = 1` for 1 cycle, then grant 3 again.
  - With `req = 8'b0001_1000` instead → the second grant is 4.
- Mid-grant reset: `rst` pulsed for 1 cycle while granting index 5 → next cycle `gnt_valid = 0`, `gnt_idx = 0`; with `req = 8'b0010_0001` the next grant is 0 (`ptr` reset).
